// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential 32-bit binary to 8-digit packed BCD converter
// using the shift-and-add-3 (double-dabble) method, one bit per clock.
//
// Build option: define BCD_SATURATE_EN to report out-of-range values as
// 32'h99999999; by default they are reported as 32'hFFFFFFFF, which the
// display driver shows as blank digits.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; bcd_out/overflow hold the last result
// S_CONVERT | one double-dabble iteration per edge, 32 edges in total
module bin_to_bcd (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd_out,
   output logic        overflow
);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_CONVERT = 1'b1;

   localparam logic [31:0] MAX_DECIMAL = 32'd99_999_999;

`ifdef BCD_SATURATE_EN
   localparam logic [31:0] OVF_CODE = 32'h9999_9999;
`else
   localparam logic [31:0] OVF_CODE = 32'hFFFF_FFFF;
`endif

   logic [0:0]  state;
   logic [31:0] shift_reg;
   logic [31:0] scratch;
   logic [4:0]  count;
   logic        overflow_pending;

   logic [31:0] scratch_adj;
   logic [63:0] shifted;
   logic [31:0] next_scratch;
   logic [31:0] next_shift;

   // Add-3 correction on every scratch digit that would exceed 9 after doubling.
   // Only 8 digits are kept: any value that needs more is flagged as overflow
   // at capture and its scratch contents are discarded.
   always_comb begin
      scratch_adj = scratch;
      for (int d = 0; d < 8; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
   end

   // Shift the corrected scratch and the remaining binary bits left together.
   always_comb begin
      shifted      = {scratch_adj, shift_reg} << 1;
      next_scratch = shifted[63:32];
      next_shift   = shifted[31:0];
   end

   assign busy = (state == S_CONVERT);

   // Control FSM, datapath registers and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         shift_reg        <= 32'h0;
         scratch          <= 32'h0;
         count            <= 5'd0;
         overflow_pending <= 1'b0;
         done             <= 1'b0;
         bcd_out          <= 32'h0;
         overflow         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  shift_reg        <= bin_in;
                  scratch          <= 32'h0;
                  count            <= 5'd31;
                  overflow_pending <= (bin_in > MAX_DECIMAL);
                  state            <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               shift_reg <= next_shift;
               scratch   <= next_scratch;
               if (count == 5'd0) begin
                  bcd_out  <= overflow_pending ? OVF_CODE : next_scratch;
                  overflow <= overflow_pending;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  count <= count - 5'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: directed bench for bin_to_bcd with an expected-result queue
// filled as conversions are started and drained on each done pulse.
module tb_bin_to_bcd;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] bin_in;
   logic        busy;
   logic        done;
   logic [31:0] bcd_out;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];
   logic        prev_done = 1'b0;

   bin_to_bcd dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: {overflow, bcd} built by repeated division by ten.
   function automatic logic [32:0] ref_of(input logic [31:0] v);
      logic [31:0] r;
      logic [31:0] x;
      if (v > 32'd99_999_999) begin
`ifdef BCD_SATURATE_EN
         return {1'b1, 32'h9999_9999};
`else
         return {1'b1, 32'hFFFF_FFFF};
`endif
      end
      r = 32'h0;
      x = v;
      for (int d = 0; d < 8; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return {1'b0, r};
   endfunction

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drain the scoreboard on every done pulse; also police pulse width.
   always @(negedge clock) begin
      if (done) begin
         logic [32:0] e;
         chk("done_single_cycle", {32'h0, prev_done}, 33'h0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 33'h1, 33'h0);
         end else begin
            e = exp_q.pop_front();
            chk("result", {overflow, bcd_out}, e);
         end
      end
      prev_done = done;
   end

   // Run one isolated conversion and check timing/hold behaviour around it.
   task automatic conv(input logic [31:0] v, input string tag);
      int          n;
      logic        stable;
      logic        bsy;
      logic [31:0] hold;
      @(negedge clock);
      start  = 1'b1;
      bin_in = v;
      exp_q.push_back(ref_of(v));
      @(posedge clock);
      #1;
      chk({tag, "_busy_e0"}, {32'h0, busy}, 33'h1);
      hold   = bcd_out;
      start  = 1'b0;
      bin_in = ~v;
      n = 0; stable = 1'b1; bsy = 1'b1;
      while (!done && n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (!done && bcd_out !== hold) stable = 1'b0;
         if (!done && !busy) bsy = 1'b0;
      end
      chk({tag, "_latency"}, 33'(n), 33'd32);
      chk({tag, "_hold"}, {32'h0, stable}, 33'h1);
      chk({tag, "_busy_hi"}, {32'h0, bsy}, 33'h1);
      chk({tag, "_busy_e32"}, {32'h0, busy}, 33'h0);
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      start  = 1'b0;
      bin_in = 32'h0;
      repeat (3) @(negedge clock);
      chk("rst_busy", {32'h0, busy}, 33'h0);
      chk("rst_done", {32'h0, done}, 33'h0);
      chk("rst_out", {overflow, bcd_out}, 33'h0);
      reset = 1'b0;

      conv(32'd0, "zero");
      conv(32'd12345678, "mid");
      conv(32'd99999999, "max");
      conv(32'd100000000, "ovf_lo");
      conv(32'hFFFFFFFF, "ovf_hi");
      conv(32'd1000, "thousand");

      // Start with 42, then a stray start (bin_in=7) at E10 and noisy bin_in.
      @(negedge clock);
      start  = 1'b1;
      bin_in = 32'd42;
      exp_q.push_back(ref_of(32'd42));
      @(posedge clock);
      #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         if (n == 9) begin
            start  = 1'b1;
            bin_in = 32'd7;
         end else begin
            start  = 1'b0;
            bin_in = $urandom;
         end
         @(posedge clock);
         #1;
         n++;
      end
      start = 1'b0;
      chk("ignore_latency", 33'(n), 33'd32);
      repeat (40) @(negedge clock);

      // Start held high: back-to-back conversions 33 cycles apart.
      @(negedge clock);
      start  = 1'b1;
      bin_in = 32'd5;
      exp_q.push_back(ref_of(32'd5));
      @(posedge clock);
      #1;
      bin_in = 32'd6;
      exp_q.push_back(ref_of(32'd6));
      n = 0;
      while (!done && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("held_first_latency", 33'(n), 33'd32);
      @(posedge clock);
      #1;
      chk("held_accept_on_done", {32'h0, busy}, 33'h1);
      start = 1'b0;
      n = 1;
      while (!done && n < 45) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("held_done_spacing", 33'(n), 33'd33);

      // Reset in the middle of a conversion aborts it without a done pulse.
      @(negedge clock);
      start  = 1'b1;
      bin_in = 32'd123456;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_busy", {32'h0, busy}, 33'h0);
      chk("abort_out", {overflow, bcd_out}, 33'h0);
      chk("abort_done", {32'h0, done}, 33'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      conv(32'd900, "after_rst");
      repeat (5) @(negedge clock);

      chk("queue_empty", 33'(exp_q.size()), 33'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
